// File: rtl/crc8_engine.sv
// crc8_engine: bit-serial CRC-8 (SMBUS style, poly 0x07, init 0x00) over a
// DATA_W-bit word, one bit per clock, MSB first. A rising edge on crc_start
// launches a run; crc_vld pulses for one cycle when crc_o holds the result.
module crc8_engine #(
  parameter int         DATA_W = 64,
  parameter logic [7:0] POLY   = 8'h07,
  parameter logic [7:0] INIT   = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              crc_start,
  output logic              crc_vld,
  output logic [7:0]        crc_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic               start_q;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic [7:0]         crc_q, crc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         crc_o_q;
  logic               crc_vld_q;

  logic               trigger;
  logic               lastBit;
  logic               loadEn;
  logic               shiftEn;
  logic               doneEn;
  logic               fb;
  logic [7:0]         crcStep;

  // Only a 0->1 transition of the level input starts a run; the edge is
  // consumed in any state, so edges seen while busy never fire later.
  assign trigger = crc_start & ~start_q;
  assign lastBit = (cnt_q == CNT_W'(DATA_W - 1));

  // One LFSR step: feedback is the CRC MSB mixed with the next message bit.
  assign fb      = crc_q[7] ^ shreg_q[DATA_W-1];
  assign crcStep = {crc_q[6:0], 1'b0} ^ (fb ? POLY : 8'h00);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE waits for an edge, CALC runs DATA_W bits, DONE is one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = CALC;
        end
      end
      CALC: begin
        if (lastBit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode: per-state datapath enables.
  always_comb begin
    loadEn  = 1'b0;
    shiftEn = 1'b0;
    doneEn  = 1'b0;
    case (state_q)
      IDLE:    loadEn  = trigger;
      CALC:    shiftEn = 1'b1;
      DONE:    doneEn  = 1'b1;
      default: begin
        loadEn  = 1'b0;
        shiftEn = 1'b0;
        doneEn  = 1'b0;
      end
    endcase
  end

  // Datapath next values: load on trigger, shift/step while calculating, hold otherwise.
  always_comb begin
    shreg_d = shreg_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    if (loadEn) begin
      shreg_d = din;
      crc_d   = INIT;
      cnt_d   = '0;
    end else if (shiftEn) begin
      shreg_d = shreg_q << 1;
      crc_d   = crcStep;
      cnt_d   = cnt_q + 1'b1;
    end
  end

  // Datapath and edge-detect registers; start_q follows crc_start in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      shreg_q <= '0;
      crc_q   <= 8'h00;
      cnt_q   <= '0;
    end else begin
      start_q <= crc_start;
      shreg_q <= shreg_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Result registers: crc_o only changes when a run completes, and the strobe
  // is registered alongside it so both appear on the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_o_q   <= 8'h00;
      crc_vld_q <= 1'b0;
    end else begin
      crc_vld_q <= doneEn;
      if (doneEn) begin
        crc_o_q <= crc_q;
      end
    end
  end

  assign crc_o   = crc_o_q;
  assign crc_vld = crc_vld_q;

endmodule

// File: tb/tb_crc8_engine.sv
// tb_crc8_engine: directed and randomized checks of crc8_engine against a
// byte-oriented software CRC-8 (poly 0x07, init 0x00) model.
module tb_crc8_engine;

  logic        clk;
  logic        rst_n;
  logic [63:0] din;
  logic        crc_start;
  logic        crc_vld;
  logic [7:0]  crc_o;

  int checks   = 0;
  int failures = 0;
  int vldCount = 0;

  // Cycles from the edge that samples the trigger up to the edge after which
  // crc_vld is seen: trigger edge + 64 CALC edges + DONE edge.
  localparam int LATENCY = 66;

  crc8_engine #(
    .DATA_W(64),
    .POLY  (8'h07),
    .INIT  (8'h00)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .crc_start(crc_start),
    .crc_vld  (crc_vld),
    .crc_o    (crc_o)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count every crc_vld pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (crc_vld === 1'b1) vldCount = vldCount + 1;
  end

  // Reference CRC-8: process the word byte by byte, most significant byte first.
  function automatic logic [7:0] crcRef(input logic [63:0] w);
    logic [7:0] c;
    c = 8'h00;
    for (int b = 7; b >= 0; b--) begin
      c = c ^ w[b*8 +: 8];
      for (int k = 0; k < 8; k++) begin
        if (c[7]) c = (c << 1) ^ 8'h07;
        else      c = c << 1;
      end
    end
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Wait for crc_vld with a bounded cycle budget; lat counts edges from the trigger edge.
  task automatic waitVld(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (crc_vld !== 1'b1 && lat < 200);
  endtask

  // Drop start for a cycle, present a word, raise start and wait for the result.
  task automatic applyStimulus(input logic [63:0] data, input string tag);
    int lat;
    int base;
    crc_start = 1'b0;
    tick();
    base      = vldCount;
    din       = data;
    crc_start = 1'b1;
    waitVld(lat);
    checkOutput({tag, "_latency"}, 64'(lat), 64'(LATENCY));
    checkOutput({tag, "_crc"}, {56'h0, crc_o}, {56'h0, crcRef(data)});
    tick();
    checkOutput({tag, "_vld_single"}, 64'(vldCount - base), 64'd1);
  endtask

  initial begin
    int          lat;
    int          base;
    logic [63:0] w;
    logic [63:0] words [3];
    logic [7:0]  first;

    $display("[TB] crc8_engine bench start");
    rst_n     = 1'b0;
    crc_start = 1'b0;
    din       = 64'h0;
    repeat (3) tick();

    // Reset state.
    checkOutput("reset_crc_o", {56'h0, crc_o}, 64'h0);
    checkOutput("reset_vld", {63'h0, crc_vld}, 64'h0);
    rst_n = 1'b1;
    tick();

    // All-zero word with start held high: one pulse, no repeats.
    base      = vldCount;
    din       = 64'h0;
    crc_start = 1'b1;
    waitVld(lat);
    checkOutput("zero_latency", 64'(lat), 64'(LATENCY));
    checkOutput("zero_crc", {56'h0, crc_o}, 64'h00);
    repeat (200) tick();
    checkOutput("zero_held_single", 64'(vldCount - base), 64'd1);

    // Known vectors and linearity.
    applyStimulus(64'h1, "w01");
    checkOutput("w01_const", {56'h0, crc_o}, 64'h07);
    applyStimulus(64'h80, "w80");
    checkOutput("w80_const", {56'h0, crc_o}, 64'h89);
    applyStimulus(64'h81, "w81");
    checkOutput("w81_const", {56'h0, crc_o}, 64'h8E);

    // Reset released together with start rising, start held ~2500 cycles.
    words[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    words[1] = 64'hABCD_ABCD_ABCD_ABCD;
    words[2] = 64'hAAAA_BBBB_CCCC_DDDD;
    for (int i = 0; i < 3; i++) begin
      rst_n     = 1'b0;
      crc_start = 1'b0;
      repeat (2) tick();
      base      = vldCount;
      din       = words[i];
      rst_n     = 1'b1;
      crc_start = 1'b1;
      waitVld(lat);
      checkOutput("rstrel_latency", 64'(lat), 64'(LATENCY));
      checkOutput("rstrel_crc", {56'h0, crc_o}, {56'h0, crcRef(words[i])});
      repeat (2500) tick();
      checkOutput("rstrel_single", 64'(vldCount - base), 64'd1);
    end

    // Start toggled and din changed during CALC: result unchanged, no queued run.
    crc_start = 1'b0;
    tick();
    w         = {$urandom, $urandom};
    base      = vldCount;
    din       = w;
    crc_start = 1'b1;
    lat       = 0;
    do begin
      tick();
      lat++;
      if (lat == 10) crc_start = 1'b0;
      if (lat == 12) begin
        crc_start = 1'b1;
        din       = ~w;
      end
    end while (crc_vld !== 1'b1 && lat < 200);
    checkOutput("toggle_latency", 64'(lat), 64'(LATENCY));
    checkOutput("toggle_crc", {56'h0, crc_o}, {56'h0, crcRef(w)});
    repeat (150) tick();
    checkOutput("toggle_single", 64'(vldCount - base), 64'd1);

    // Reset at CALC cycle 30: immediate clear, no pulse, then a clean run.
    applyStimulus(64'h80, "pre_abort");
    crc_start = 1'b0;
    tick();
    base      = vldCount;
    din       = {$urandom, $urandom};
    crc_start = 1'b1;
    repeat (31) tick();
    rst_n = 1'b0;
    #1;
    checkOutput("abort_crc_o", {56'h0, crc_o}, 64'h0);
    checkOutput("abort_vld", {63'h0, crc_vld}, 64'h0);
    crc_start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (100) tick();
    checkOutput("abort_no_pulse", 64'(vldCount - base), 64'd0);
    applyStimulus({$urandom, $urandom}, "post_abort");

    // Back-to-back: retrigger right after crc_vld; crc_o holds until the second result.
    crc_start = 1'b0;
    tick();
    w         = {$urandom, $urandom};
    din       = w;
    crc_start = 1'b1;
    tick();
    crc_start = 1'b0;
    lat       = 1;
    while (crc_vld !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    checkOutput("b2b_first_latency", 64'(lat), 64'(LATENCY));
    checkOutput("b2b_first_crc", {56'h0, crc_o}, {56'h0, crcRef(w)});
    first     = crcRef(w);
    w         = {$urandom, $urandom};
    din       = w;
    crc_start = 1'b1;
    for (int i = 1; i <= LATENCY - 1; i++) begin
      tick();
      if (i == 1 || i == 30 || i == LATENCY - 1) begin
        checkOutput("b2b_hold_crc_o", {56'h0, crc_o}, {56'h0, first});
        checkOutput("b2b_hold_vld", {63'h0, crc_vld}, 64'h0);
      end
    end
    tick();
    checkOutput("b2b_second_vld", {63'h0, crc_vld}, 64'h1);
    checkOutput("b2b_second_crc", {56'h0, crc_o}, {56'h0, crcRef(w)});

    // Randomized words against the model.
    for (int i = 0; i < 8; i++) begin
      applyStimulus({$urandom, $urandom}, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
